// File: rtl/regfile_writeback.sv
// Register-file writeback initiator: arbitrates multdiv and ALU results onto one write port.
// Optional macro REGFILE_WRITEBACK_FORWARD_EN adds combinational write-to-read forwarding.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  // alu_valid/alu_stall: a result transfers on an edge where alu_valid=1 and
  // alu_stall=0; while alu_stall=1 upstream holds alu_rd/alu_data stable.
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_ready,
  input  logic [31:0] md_data,
  output logic        md_busy,
  output logic        md_issue_err,
  output logic [31:0] busy_mask,
`ifdef REGFILE_WRITEBACK_FORWARD_EN
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_regA_in,
  input  logic [31:0] data_regB_in,
  output logic [31:0] data_fwdA,
  output logic [31:0] data_fwdB,
`endif
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    md_rd;

  logic        md_win, md_write, alu_ok, pop, push, direct, md_accept;
  logic [31:0] busy_mask_nxt;

  assign alu_stall = (count == (AW+1)'(DEPTH));

  always_comb begin
    md_win    = md_ready && md_busy;
    // An r0 multdiv result still retires the op, but never reaches the write port.
    md_write  = md_win && (md_rd != 5'd0);
    alu_ok    = alu_valid && !alu_stall && (alu_rd != 5'd0);
    pop       = !md_write && (count != '0);
    direct    = !md_write && (count == '0) && alu_ok;
    push      = alu_ok && !direct;
    md_accept = md_issue && (!md_busy || md_ready);
    busy_mask_nxt = busy_mask;
    if (md_win) busy_mask_nxt[md_rd] = 1'b0;
    if (md_accept && (md_issue_rd != 5'd0)) busy_mask_nxt[md_issue_rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      md_busy          <= 1'b0;
      md_rd            <= 5'd0;
      busy_mask        <= 32'd0;
      md_issue_err     <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);

      if (md_accept) begin
        md_busy <= 1'b1;
        md_rd   <= md_issue_rd;
      end else if (md_win) begin
        md_busy <= 1'b0;
      end
      busy_mask    <= busy_mask_nxt;
      md_issue_err <= md_issue && md_busy && !md_ready;

      if (md_write) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= md_rd;
        data_writeReg    <= md_data;
      end else if (pop) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= fifo_rd[rd_ptr];
        data_writeReg    <= fifo_data[rd_ptr];
      end else if (direct) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= alu_rd;
        data_writeReg    <= alu_data;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end
  end

`ifdef REGFILE_WRITEBACK_FORWARD_EN
  assign data_fwdA = (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegA && ctrl_readRegA != 5'd0)
                     ? data_writeReg : data_regA_in;
  assign data_fwdB = (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegB && ctrl_readRegB != 5'd0)
                     ? data_writeReg : data_regB_in;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback with hand-computed expectations.
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_ready;
  logic [31:0] md_data;
  logic        md_busy;
  logic        md_issue_err;
  logic [31:0] busy_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
`ifdef REGFILE_WRITEBACK_FORWARD_EN
  logic [4:0]  ctrl_readRegA = 5'd0, ctrl_readRegB = 5'd0;
  logic [31:0] data_regA_in = 32'd0, data_regB_in = 32'd0;
  logic [31:0] data_fwdA, data_fwdB;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  regfile_writeback #(.DEPTH(4), .AW(2)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd), .md_ready(md_ready), .md_data(md_data),
    .md_busy(md_busy), .md_issue_err(md_issue_err), .busy_mask(busy_mask),
`ifdef REGFILE_WRITEBACK_FORWARD_EN
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_regA_in(data_regA_in), .data_regB_in(data_regB_in),
    .data_fwdA(data_fwdA), .data_fwdB(data_fwdB),
`endif
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    md_issue = 1'b0; md_issue_rd = 5'd0; md_ready = 1'b0; md_data = 32'd0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1; alu_rd = rd; alu_data = data;
  endtask

  // Scoreboard: compare the write port against the head of exp_q
  task automatic expect_write(input string tag);
    logic [36:0] e;
    e = exp_q.pop_front();
    check({tag, "_we"},   {31'd0, ctrl_writeEnable}, 32'd1);
    check({tag, "_reg"},  {27'd0, ctrl_writeReg}, {27'd0, e[36:32]});
    check({tag, "_data"}, data_writeReg, e[31:0]);
  endtask

  initial begin
    drive_idle();
    ctrl_reset = 1'b1;
    tick(); tick();
    ctrl_reset = 1'b0;
    check("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("rst_reg", {27'd0, ctrl_writeReg}, 32'd0);
    check("rst_data", data_writeReg, 32'd0);
    check("rst_stall", {31'd0, alu_stall}, 32'd0);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_mask", busy_mask, 32'd0);
    check("rst_err", {31'd0, md_issue_err}, 32'd0);

    // Single ALU write, direct path
    drive_alu(5'd5, 32'h1234);
    exp_q.push_back({5'd5, 32'h1234});
    tick(); drive_idle();
    expect_write("alu1");
    tick();
    check("alu1_idle_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("alu1_hold_data", data_writeReg, 32'h1234);

    // rd=0 is discarded
    drive_alu(5'd0, 32'hFFFF);
    tick(); drive_idle();
    check("r0_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("r0_stall", {31'd0, alu_stall}, 32'd0);
    tick();
    check("r0_no_pop", {31'd0, ctrl_writeEnable}, 32'd0);

    // Multdiv issue, then result colliding with ALU
    md_issue = 1'b1; md_issue_rd = 5'd7;
    tick(); drive_idle();
    check("md7_mask", busy_mask, 32'h80);
    check("md7_busy", {31'd0, md_busy}, 32'd1);
    repeat (4) tick();
    md_ready = 1'b1; md_data = 32'hCAFE;
    drive_alu(5'd3, 32'h11);
    exp_q.push_back({5'd7, 32'hCAFE});
    exp_q.push_back({5'd3, 32'h11});
    tick(); drive_idle();
    expect_write("md7");
    check("md7_mask_clr", busy_mask, 32'd0);
    check("md7_busy_clr", {31'd0, md_busy}, 32'd0);
    tick();
    expect_write("alu3");
    tick();
    check("alu3_idle_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // Fill FIFO while multdiv wins four cycles in a row
    md_issue = 1'b1; md_issue_rd = 5'd20;
    tick();
    for (int i = 0; i < 4; i++) begin
      md_issue = (i < 3); md_issue_rd = 5'd20;
      md_ready = 1'b1; md_data = 32'hD0 + i;
      drive_alu(5'(i + 1), 32'hA0 + i);
      tick();
      check("md20_we", {31'd0, ctrl_writeEnable}, 32'd1);
      check("md20_reg", {27'd0, ctrl_writeReg}, 32'd20);
      check("md20_data", data_writeReg, 32'hD0 + i);
    end
    md_issue = 1'b0; md_ready = 1'b0;
    check("full_stall", {31'd0, alu_stall}, 32'd1);
    check("full_busy", {31'd0, md_busy}, 32'd0);
    check("full_mask", busy_mask, 32'd0);
    for (int i = 0; i < 5; i++) exp_q.push_back({5'(i + 1), 32'hA0 + i});
    drive_alu(5'd5, 32'hA4);
    tick();  // stalled: r5 ignored, r1 popped
    expect_write("drain1");
    check("drain1_stall", {31'd0, alu_stall}, 32'd0);
    tick();  // r5 accepted into FIFO while r2 pops
    drive_idle();
    expect_write("drain2");
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_write("drain");
    end
    tick();
    check("drain_idle_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // Issue while busy
    md_issue = 1'b1; md_issue_rd = 5'd9;
    tick();
    check("md9_mask", busy_mask, 32'h200);
    check("md9_err0", {31'd0, md_issue_err}, 32'd0);
    md_issue_rd = 5'd10;
    tick(); drive_idle();
    check("md10_err", {31'd0, md_issue_err}, 32'd1);
    check("md10_mask", busy_mask, 32'h200);
    tick();
    check("md10_err_clr", {31'd0, md_issue_err}, 32'd0);
    check("md10_mask_hold", busy_mask, 32'h200);

    // Two buffered entries plus outstanding op, then reset
    md_ready = 1'b1; md_data = 32'h99; md_issue = 1'b1; md_issue_rd = 5'd11;
    drive_alu(5'd12, 32'h12);
    tick();
    check("pre_rst_reg9", {27'd0, ctrl_writeReg}, 32'd9);
    md_data = 32'hBB;
    drive_alu(5'd13, 32'h13);
    tick(); drive_idle();
    check("pre_rst_mask", busy_mask, 32'h800);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    check("mid_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("mid_rst_reg", {27'd0, ctrl_writeReg}, 32'd0);
    check("mid_rst_data", data_writeReg, 32'd0);
    check("mid_rst_busy", {31'd0, md_busy}, 32'd0);
    check("mid_rst_mask", busy_mask, 32'd0);
    check("mid_rst_stall", {31'd0, alu_stall}, 32'd0);
    md_ready = 1'b1; md_data = 32'hBEEF;
    tick(); drive_idle();
    check("post_rst_md_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("post_rst_md_data", data_writeReg, 32'd0);
    tick();
    check("post_rst_fifo_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
